// File: rtl/s_machine_pkg.sv
// Shared definitions for the data-memory responder: default widths, request direction
// encoding and responder state encoding.
package s_machine_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_e;

endpackage

// File: rtl/sm_mem_array.sv
// Word store: synchronous write, combinational read, no reset.
// Contents are undefined until written.
module sm_mem_array #(
  parameter int ADDR_W = 8,
  parameter int WIDTH  = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_memory_responder.sv
// CPU data-memory responder: one request in flight, fixed read/write latency, one-cycle ack.
// Optional per-word even parity is built when MEM_PARITY_EN is defined.
module data_memory_responder
  import s_machine_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              read_write_memory,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_out_memory,
  output logic [DATA_W-1:0] data_in_memory,
  output logic              ack,
  output logic              busy,
  output logic              overrun,
  input  logic              inject_parity_err,
  output logic              parity_err
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT <= 2) ? 1 : $clog2(MAX_LAT);
  localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'((WRITE_LATENCY > 1) ? WRITE_LATENCY - 2 : 0);
  localparam logic RD_DIRECT = (READ_LATENCY == 1);
  localparam logic WR_DIRECT = (WRITE_LATENCY == 1);

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  resp_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              overrun_q;

  logic              req_is_wr;
  logic              accept;
  logic              rd_resp;
  logic              mem_we;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  mem_rdata;
  logic              par_mismatch;

  assign req_is_wr = (read_write_memory == RW_WRITE);
  assign accept    = (state_q == ST_IDLE) && req;
  assign rd_resp   = (state_q == ST_RESP) && (rw_q == RW_READ);
  assign mem_we    = (state_q == ST_RESP) && (rw_q == RW_WRITE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (req_is_wr ? WR_DIRECT : RD_DIRECT) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = req_is_wr ? WR_CNT_INIT : RD_CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outside a read ack the read bus shows the last value returned.
  always_comb begin
    ack            = (state_q == ST_RESP);
    busy           = (state_q != ST_IDLE);
    data_in_memory = rd_resp ? mem_rdata[DATA_W-1:0] : rdata_q;
    parity_err     = rd_resp && par_mismatch;
    overrun        = overrun_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      rw_q      <= RW_READ;
      wdata_q   <= '0;
      rdata_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        rw_q    <= read_write_memory;
        wdata_q <= data_out_memory;
      end
      if (rd_resp) rdata_q <= mem_rdata[DATA_W-1:0];
      overrun_q <= overrun_q | (req & busy);
    end
  end

`ifdef MEM_PARITY_EN
  logic inj_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    inj_q <= 1'b0;
    else if (accept) inj_q <= inject_parity_err;
  end

  // Top bit holds even parity of the data word, optionally corrupted on request.
  assign mem_wdata    = {(^wdata_q) ^ inj_q, wdata_q};
  assign par_mismatch = ^mem_rdata;
`else
  logic unused_inj;

  assign unused_inj   = inject_parity_err;
  assign mem_wdata    = wdata_q;
  assign par_mismatch = 1'b0;
`endif

  sm_mem_array #(
    .ADDR_W (ADDR_W),
    .WIDTH  (MEM_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (addr_q),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench: two responders (default latencies, and read=4/write=3) driven by the same requests,
// checked against an array-based memory model.
module tb_data_memory_responder;

`ifdef MEM_PARITY_EN
  localparam bit MEM_PAR = 1'b1;
`else
  localparam bit MEM_PAR = 1'b0;
`endif
  localparam int LAT_D_RD = 2, LAT_D_WR = 1, LAT_L_RD = 4, LAT_L_WR = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic        read_write_memory;
  logic [7:0]  addr;
  logic [15:0] data_out_memory;
  logic        inject_parity_err;

  logic [15:0] d_data, l_data;
  logic        d_ack, d_busy, d_ovr, d_perr;
  logic        l_ack, l_busy, l_ovr, l_perr;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_m [256];
  bit          inj_m [256];
  logic [15:0] last_d, last_l;
  bit          ovr_exp;

  always #5 clk = ~clk;

  data_memory_responder u_d (
    .clk(clk), .reset_n(reset_n), .req(req), .read_write_memory(read_write_memory),
    .addr(addr), .data_out_memory(data_out_memory), .data_in_memory(d_data),
    .ack(d_ack), .busy(d_busy), .overrun(d_ovr),
    .inject_parity_err(inject_parity_err), .parity_err(d_perr)
  );

  data_memory_responder #(.READ_LATENCY(LAT_L_RD), .WRITE_LATENCY(LAT_L_WR)) u_l (
    .clk(clk), .reset_n(reset_n), .req(req), .read_write_memory(read_write_memory),
    .addr(addr), .data_out_memory(data_out_memory), .data_in_memory(l_data),
    .ack(l_ack), .busy(l_busy), .overrun(l_ovr),
    .inject_parity_err(inject_parity_err), .parity_err(l_perr)
  );

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected view of one responder in cycle T+k of a request issued in cycle T.
  task automatic chk_inst(input string p, input int lat, input int k, input bit rw,
                          input logic [7:0] a, input logic [15:0] dat, input logic ack_o,
                          input logic busy_o, input logic ovr_o, input logic perr_o,
                          inout logic [15:0] last);
    bit rd_ack;
    rd_ack = (k == lat) && !rw;
    chk_b({p, "_ack"}, ack_o, k == lat);
    chk_b({p, "_busy"}, busy_o, k <= lat);
    chk_b({p, "_overrun"}, ovr_o, ovr_exp);
    chk_w({p, "_rdata"}, dat, rd_ack ? mem_m[a] : last);
    chk_b({p, "_parity_err"}, perr_o, rd_ack ? (MEM_PAR && inj_m[a]) : 1'b0);
    if (rd_ack) last = mem_m[a];
  endtask

  task automatic chk_reset_outputs(input string p);
    chk_b({p, "_rst_ack_d"}, d_ack, 1'b0);
    chk_b({p, "_rst_busy_d"}, d_busy, 1'b0);
    chk_w({p, "_rst_data_d"}, d_data, 16'h0);
    chk_b({p, "_rst_ovr_d"}, d_ovr, 1'b0);
    chk_b({p, "_rst_perr_d"}, d_perr, 1'b0);
    chk_b({p, "_rst_ack_l"}, l_ack, 1'b0);
    chk_b({p, "_rst_busy_l"}, l_busy, 1'b0);
    chk_w({p, "_rst_data_l"}, l_data, 16'h0);
    chk_b({p, "_rst_ovr_l"}, l_ovr, 1'b0);
  endtask

  // One request; extra=1 holds req into cycle T+1 to provoke an overrun.
  task automatic do_op(input bit rw, input logic [7:0] a, input logic [15:0] d,
                       input bit inj, input bit extra);
    int ld, ll;
    ld = rw ? LAT_D_WR : LAT_D_RD;
    ll = rw ? LAT_L_WR : LAT_L_RD;
    @(posedge clk); #1;
    req = 1'b1; read_write_memory = rw; addr = a; data_out_memory = d; inject_parity_err = inj;
    @(negedge clk);
    chk_b("idle_busy_d", d_busy, 1'b0);
    chk_b("idle_busy_l", l_busy, 1'b0);
    @(posedge clk); #1;
    if (extra) begin
      addr = a + 8'd1; read_write_memory = 1'b1; data_out_memory = ~d;
    end else begin
      req = 1'b0;
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (extra && k == 2) ovr_exp = 1'b1;
      chk_inst("dflt", ld, k, rw, a, d_data, d_ack, d_busy, d_ovr, d_perr, last_d);
      chk_inst("long", ll, k, rw, a, l_data, l_ack, l_busy, l_ovr, l_perr, last_l);
      if (k == 1) begin
        @(posedge clk); #1;
        req = 1'b0;
      end
    end
    if (rw) begin
      mem_m[a] = d;
      inj_m[a] = inj;
    end
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; read_write_memory = 1'b0; addr = '0;
    data_out_memory = '0; inject_parity_err = 1'b0;
    last_d = '0; last_l = '0; ovr_exp = 1'b0;
    #12;
    chk_reset_outputs("init");
    @(negedge clk); reset_n = 1'b1;

    // Write then read back one word.
    do_op(1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0);
    do_op(1'b0, 8'h10, 16'h0000, 1'b0, 1'b0);

    // Both ends of the address space are independent.
    do_op(1'b1, 8'hFF, 16'h1234, 1'b0, 1'b0);
    do_op(1'b1, 8'h00, 16'h5678, 1'b0, 1'b0);
    do_op(1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0);
    do_op(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) do_op(1'b1, 8'h20 + 8'(i), 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      do_op(1'($urandom_range(0, 1)), 8'h20 + 8'($urandom_range(0, 15)),
            16'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    // Request during a read is dropped and overrun stays set.
    do_op(1'b0, 8'h10, 16'h0000, 1'b0, 1'b1);
    do_op(1'b0, 8'h11, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      do_op(1'($urandom_range(0, 1)), 8'h20 + 8'($urandom_range(0, 15)),
            16'($urandom), 1'b0, 1'b0);

    // Reset during an in-flight write aborts it without committing.
    do_op(1'b1, 8'h05, 16'h3C3C, 1'b0, 1'b0);
    @(posedge clk); #1;
    req = 1'b1; read_write_memory = 1'b1; addr = 8'h05; data_out_memory = 16'hAAAA;
    @(posedge clk); #1;
    req = 1'b0; reset_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    ovr_exp = 1'b0; last_d = '0; last_l = '0;
    repeat (2) begin
      @(negedge clk);
      chk_b("abort_ack_d", d_ack, 1'b0);
      chk_b("abort_ack_l", l_ack, 1'b0);
    end
    reset_n = 1'b1;
    do_op(1'b0, 8'h05, 16'h0000, 1'b0, 1'b0);

    // Parity injection and a clean word.
    do_op(1'b1, 8'h30, 16'h0001, 1'b1, 1'b0);
    do_op(1'b0, 8'h30, 16'h0000, 1'b0, 1'b0);
    do_op(1'b1, 8'h31, 16'h0003, 1'b0, 1'b0);
    do_op(1'b0, 8'h31, 16'h0000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
